// File: rtl/mac_loop_ctrl_pkg.sv
// rtl/mac_loop_ctrl_pkg.sv - shared constants, microcode types and FSM encodings for the MAC loop controller
package mac_loop_ctrl_pkg;

    localparam int MAC_NB_LOOPS   = 2;
    localparam int MAC_NB_OFFS    = 4;
    localparam int MAC_CNT_WIDTH  = 16;
    localparam int MAC_OFFS_WIDTH = 32;

    localparam int MAC_UCODE_A_OFFS = 0;
    localparam int MAC_UCODE_B_OFFS = 1;
    localparam int MAC_UCODE_C_OFFS = 2;
    localparam int MAC_UCODE_D_OFFS = 3;

    // accum_loop is carried for the FSM microcode word; this block does not consume it.
    typedef struct packed {
        logic enable;
        logic clear;
        logic accum_loop;
    } ctrl_ucode_t;

    typedef struct packed {
        logic [MAC_NB_OFFS-1:0][MAC_OFFS_WIDTH-1:0] offs;
        logic [MAC_NB_LOOPS-1:0][MAC_CNT_WIDTH-1:0] idx;
        logic                                       valid;
        logic                                       done;
        logic                                       busy;
    } flags_ucode_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_COUNT = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;

endpackage

// File: rtl/mac_loop_ctrl_if.sv
// rtl/mac_loop_ctrl_if.sv - request/result bundle between the MAC control FSM and the loop controller
interface mac_loop_ctrl_if #(
    parameter int NB_LOOPS   = mac_loop_ctrl_pkg::MAC_NB_LOOPS,
    parameter int NB_OFFS    = mac_loop_ctrl_pkg::MAC_NB_OFFS,
    parameter int CNT_WIDTH  = mac_loop_ctrl_pkg::MAC_CNT_WIDTH,
    parameter int OFFS_WIDTH = mac_loop_ctrl_pkg::MAC_OFFS_WIDTH
);

    logic                                             clear_i;
    logic                                             enable_i;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]               loop_bound_i;
    logic [NB_LOOPS-1:0][NB_OFFS-1:0][OFFS_WIDTH-1:0] stride_i;
    logic [NB_OFFS-1:0][OFFS_WIDTH-1:0]               offs_o;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]               idx_o;
    logic                                             valid_o;
    logic                                             done_o;
    logic                                             busy_o;

    modport master (
        output clear_i, enable_i, loop_bound_i, stride_i,
        input  offs_o, idx_o, valid_o, done_o, busy_o
    );

    modport slave (
        input  clear_i, enable_i, loop_bound_i, stride_i,
        output offs_o, idx_o, valid_o, done_o, busy_o
    );

endinterface

// File: rtl/mac_loop_counter.sv
// rtl/mac_loop_counter.sv - one loop level: index register with bound compare, carry chain and wrap
module mac_loop_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 step_i,
    input  logic                 carry_in_i,
    input  logic [CNT_WIDTH-1:0] bound_i,
    output logic [CNT_WIDTH-1:0] idx_o,
    output logic                 carry_out_o
);

    logic [CNT_WIDTH-1:0] idx_q, idx_d;
    logic [CNT_WIDTH-1:0] last_idx;
    logic                 at_last;

    // A zero bound behaves as a single-iteration level; >= keeps a shrunk bound from running away.
    assign last_idx    = (bound_i == '0) ? '0 : bound_i - CNT_WIDTH'(1);
    assign at_last     = (idx_q >= last_idx);
    assign carry_out_o = carry_in_i & at_last;

    always_comb begin
        idx_d = idx_q;
        if (clear_i) begin
            idx_d = '0;
        end else if (step_i && carry_in_i) begin
            idx_d = at_last ? '0 : idx_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx_o = idx_q;

endmodule

// File: rtl/mac_loop_ctrl.sv
// rtl/mac_loop_ctrl.sv - nested loop walker producing per-stream byte offsets for the MAC control FSM
module mac_loop_ctrl import mac_loop_ctrl_pkg::*; #(
    parameter int NB_LOOPS   = MAC_NB_LOOPS,
    parameter int NB_OFFS    = MAC_NB_OFFS,
    parameter int CNT_WIDTH  = MAC_CNT_WIDTH,
    parameter int OFFS_WIDTH = MAC_OFFS_WIDTH
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mac_loop_ctrl_if.slave bus
);

    logic [1:0]                         state_q, state_d;
    logic                               done_q, done_d;
    logic                               hit_q, hit_d;
    logic                               valid_q, valid_d;
    logic [NB_OFFS-1:0][OFFS_WIDTH-1:0] offs_q, offs_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx_q, idx_d;

    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] cnt_idx;
    logic [NB_OFFS-1:0][OFFS_WIDTH-1:0] offs_calc;
    logic [NB_LOOPS:0]                  carry;
    logic                               exhaust;
    logic                               cnt_step;

    // Level 0 always sees a carry, so carry[NB_LOOPS] flags that the next step would leave the space.
    assign carry[0] = 1'b1;
    assign exhaust  = carry[NB_LOOPS];
    assign cnt_step = (state_q == ST_COUNT) && !done_q && !exhaust;

    for (genvar l = 0; l < NB_LOOPS; l++) begin : g_lvl
        mac_loop_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .clear_i     (bus.clear_i),
            .step_i      (cnt_step),
            .carry_in_i  (carry[l]),
            .bound_i     (bus.loop_bound_i[l]),
            .idx_o       (cnt_idx[l]),
            .carry_out_o (carry[l+1])
        );
    end

    always_comb begin
        offs_calc = '0;
        for (int o = 0; o < NB_OFFS; o++) begin
            for (int l = 0; l < NB_LOOPS; l++) begin
                offs_calc[o] = offs_calc[o] + OFFS_WIDTH'(cnt_idx[l]) * bus.stride_i[l][o];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        hit_d   = hit_q;
        valid_d = 1'b0;
        offs_d  = offs_q;
        idx_d   = idx_q;
        if (bus.clear_i) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            hit_d   = 1'b0;
            offs_d  = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable_i) begin
                        state_d = ST_COUNT;
                    end
                end
                ST_COUNT: begin
                    hit_d   = !done_q && exhaust;
                    state_d = ST_ACCUM;
                end
                ST_ACCUM: begin
                    // Published results only move when the counters actually stepped.
                    if (!done_q && !hit_q) begin
                        offs_d = offs_calc;
                        idx_d  = cnt_idx;
                    end
                    done_d  = done_q | hit_q;
                    valid_d = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            valid_q <= 1'b0;
            offs_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            valid_q <= valid_d;
            offs_q  <= offs_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.offs_o  = offs_q;
    assign bus.idx_o   = idx_q;
    assign bus.valid_o = valid_q;
    assign bus.done_o  = done_q;
    assign bus.busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mac_loop_ctrl.sv
// tb/tb_mac_loop_ctrl.sv - scoreboard bench for mac_loop_ctrl
module tb_mac_loop_ctrl;
    import mac_loop_ctrl_pkg::*;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] d;
        logic [15:0] i0;
        logic [15:0] i1;
        logic        dn;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   pops;
    logic prev_valid;
    exp_t q[$];
    exp_t mon_e;

    mac_loop_ctrl_if #(
        .NB_LOOPS   (MAC_NB_LOOPS),
        .NB_OFFS    (MAC_NB_OFFS),
        .CNT_WIDTH  (MAC_CNT_WIDTH),
        .OFFS_WIDTH (MAC_OFFS_WIDTH)
    ) bus ();

    mac_loop_ctrl #(
        .NB_LOOPS   (MAC_NB_LOOPS),
        .NB_OFFS    (MAC_NB_OFFS),
        .CNT_WIDTH  (MAC_CNT_WIDTH),
        .OFFS_WIDTH (MAC_OFFS_WIDTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(posedge clk) begin
        #1;
        if (bus.valid_o === 1'b1) begin
            chk("valid_back_to_back", {63'd0, prev_valid}, 64'd0);
            if (q.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("FAIL unexpected_valid: got valid_o=1, required no pulse (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("offs_a", 64'(bus.offs_o[MAC_UCODE_A_OFFS]), 64'(mon_e.a));
                chk("offs_b", 64'(bus.offs_o[MAC_UCODE_B_OFFS]), 64'(mon_e.b));
                chk("offs_d", 64'(bus.offs_o[MAC_UCODE_D_OFFS]), 64'(mon_e.d));
                chk("idx0", 64'(bus.idx_o[0]), 64'(mon_e.i0));
                chk("idx1", 64'(bus.idx_o[1]), 64'(mon_e.i1));
                chk("done", 64'(bus.done_o), 64'(mon_e.dn));
                chk("busy_at_valid", 64'(bus.busy_o), 64'd0);
                pops = pops + 1;
            end
        end
        prev_valid = bus.valid_o;
    end

    task automatic cfg(input logic [15:0] b0, input logic [15:0] b1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] s_b0, input logic [31:0] s_b1,
                       input logic [31:0] d0, input logic [31:0] d1);
        bus.loop_bound_i[0] = b0;
        bus.loop_bound_i[1] = b1;
        bus.stride_i[0][MAC_UCODE_A_OFFS] = a0;
        bus.stride_i[1][MAC_UCODE_A_OFFS] = a1;
        bus.stride_i[0][MAC_UCODE_B_OFFS] = s_b0;
        bus.stride_i[1][MAC_UCODE_B_OFFS] = s_b1;
        bus.stride_i[0][MAC_UCODE_C_OFFS] = 32'd0;
        bus.stride_i[1][MAC_UCODE_C_OFFS] = 32'd0;
        bus.stride_i[0][MAC_UCODE_D_OFFS] = d0;
        bus.stride_i[1][MAC_UCODE_D_OFFS] = d1;
    endtask

    task automatic wait_pops(input int target);
        for (int k = 0; k < 12 && pops < target; k++) @(negedge clk);
        checks = checks + 1;
        if (pops < target) begin
            errors = errors + 1;
            $display("FAIL valid_timeout: got %0d pulses, required %0d", pops, target);
        end
    endtask

    task automatic do_enable(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                             input logic [15:0] i0, input logic [15:0] i1, input logic dn);
        exp_t e;
        int   target;
        @(negedge clk);
        e = '{a, b, d, i0, i1, dn, cyc + 3};
        q.push_back(e);
        target = pops + 1;
        bus.enable_i = 1'b1;
        @(negedge clk);
        bus.enable_i = 1'b0;
        wait_pops(target);
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear_i = 1'b1;
        @(negedge clk);
        bus.clear_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   c;
        int   target;
        checks       = 0;
        errors       = 0;
        pops         = 0;
        prev_valid   = 1'b0;
        rst          = 1'b1;
        bus.clear_i  = 1'b0;
        bus.enable_i = 1'b0;
        cfg(16'd3, 16'd2, 32'd4, 32'd12, 32'd2, 32'd5, 32'd0, 32'd4);

        repeat (2) @(negedge clk);
        chk("rst_idx0", 64'(bus.idx_o[0]), 64'd0);
        chk("rst_idx1", 64'(bus.idx_o[1]), 64'd0);
        chk("rst_offs_a", 64'(bus.offs_o[MAC_UCODE_A_OFFS]), 64'd0);
        chk("rst_offs_d", 64'(bus.offs_o[MAC_UCODE_D_OFFS]), 64'd0);
        chk("rst_valid", 64'(bus.valid_o), 64'd0);
        chk("rst_done", 64'(bus.done_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        rst = 1'b0;

        // Async reset in the middle of an update
        do_enable(32'd4, 32'd2, 32'd0, 16'd1, 16'd0, 1'b0);
        do_enable(32'd8, 32'd4, 32'd0, 16'd2, 16'd0, 1'b0);
        @(negedge clk);
        bus.enable_i = 1'b1;
        @(negedge clk);
        bus.enable_i = 1'b0;
        chk("busy_in_update", 64'(bus.busy_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("midrst_idx0", 64'(bus.idx_o[0]), 64'd0);
        chk("midrst_offs_a", 64'(bus.offs_o[MAC_UCODE_A_OFFS]), 64'd0);
        chk("midrst_offs_b", 64'(bus.offs_o[MAC_UCODE_B_OFFS]), 64'd0);
        chk("midrst_busy", 64'(bus.busy_o), 64'd0);
        chk("midrst_valid", 64'(bus.valid_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Clear together with enable: clear wins, no pulse
        do_enable(32'd4, 32'd2, 32'd0, 16'd1, 16'd0, 1'b0);
        do_enable(32'd8, 32'd4, 32'd0, 16'd2, 16'd0, 1'b0);
        @(negedge clk);
        bus.clear_i  = 1'b1;
        bus.enable_i = 1'b1;
        @(negedge clk);
        bus.clear_i  = 1'b0;
        bus.enable_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("clr_idx0", 64'(bus.idx_o[0]), 64'd0);
        chk("clr_offs_a", 64'(bus.offs_o[MAC_UCODE_A_OFFS]), 64'd0);
        chk("clr_busy", 64'(bus.busy_o), 64'd0);

        // Full nested walk, exhaustion and an enable after done
        do_enable(32'd4,  32'd2, 32'd0, 16'd1, 16'd0, 1'b0);
        do_enable(32'd8,  32'd4, 32'd0, 16'd2, 16'd0, 1'b0);
        do_enable(32'd12, 32'd5, 32'd4, 16'd0, 16'd1, 1'b0);
        do_enable(32'd16, 32'd7, 32'd4, 16'd1, 16'd1, 1'b0);
        do_enable(32'd20, 32'd9, 32'd4, 16'd2, 16'd1, 1'b0);
        do_enable(32'd20, 32'd9, 32'd4, 16'd2, 16'd1, 1'b1);
        do_enable(32'd20, 32'd9, 32'd4, 16'd2, 16'd1, 1'b1);

        // Enable held high for four sampling edges
        do_clear();
        @(negedge clk);
        c = cyc;
        target = pops + 2;
        e = '{32'd4, 32'd2, 32'd0, 16'd1, 16'd0, 1'b0, c + 3};
        q.push_back(e);
        e = '{32'd8, 32'd4, 32'd0, 16'd2, 16'd0, 1'b0, c + 6};
        q.push_back(e);
        bus.enable_i = 1'b1;
        repeat (4) @(negedge clk);
        bus.enable_i = 1'b0;
        wait_pops(target);

        // Degenerate bounds: single iteration space
        do_clear();
        cfg(16'd0, 16'd1, 32'd4, 32'd12, 32'd2, 32'd5, 32'd0, 32'd4);
        do_enable(32'd0, 32'd0, 32'd0, 16'd0, 16'd0, 1'b1);

        // Offset wrap-around modulo 2^32
        do_clear();
        cfg(16'd3, 16'd1, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
        do_enable(32'hFFFF_FFFC, 32'd0, 32'd0, 16'd1, 16'd0, 1'b0);
        do_enable(32'hFFFF_FFF8, 32'd0, 32'd0, 16'd2, 16'd0, 1'b0);

        repeat (4) @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
